// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package deser_pkg;

    localparam int unsigned DESER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers the input level and flags the first cycle it reads 1 after a 0.
module edge_detect (
    input  logic clock_1M,
    input  logic reset,
    input  logic level,
    output logic pulse_c
);

    logic level_q;

    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse_c = level & ~level_q;

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel deserializer with ready/ack handshake and sticky overflow.
// Define DESER_PARITY_EN to expect a trailing even-parity bit per word and report parity_err.
module deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = DESER_WIDTH
) (
    input  logic             clock_1M,
    input  logic             reset,
    input  logic             bit_strobe,
    input  logic             write_in,
    input  logic             data_in,
    input  logic             ack_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_ready,
    output logic             status_out,
    output logic             overflow,
    output logic             parity_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
`ifdef DESER_PARITY_EN
    localparam int unsigned SR_W      = WIDTH;
    localparam int unsigned WORD_BITS = WIDTH + 1;
`else
    localparam int unsigned SR_W      = WIDTH - 1;
    localparam int unsigned WORD_BITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BITS - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  bit_count;
    logic [SR_W-1:0]   sr;
    logic              slot_c;
    logic              accept_c;
    logic              shift_c;
    logic              start_c;
    logic              complete_c;
    logic              ack_c;
    logic              ovf_set_c;
    logic [WIDTH-1:0]  word_c;

    edge_detect u_edge_detect (
        .clock_1M (clock_1M),
        .reset    (reset),
        .level    (bit_strobe),
        .pulse_c  (slot_c)
    );

    assign accept_c = slot_c & write_in;

    // The shift register holds all bits but the one arriving in the completing slot.
`ifdef DESER_PARITY_EN
    assign word_c = sr;
`else
    assign word_c = {sr, data_in};
`endif

    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        shift_c    = 1'b0;
        start_c    = 1'b0;
        complete_c = 1'b0;
        ack_c      = 1'b0;
        ovf_set_c  = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    next_state = COLLECT;
                    shift_c    = 1'b1;
                    start_c    = 1'b1;
                end
            end
            COLLECT: begin
                if (accept_c) begin
                    shift_c = 1'b1;
                    if (bit_count == LAST_IDX) begin
                        next_state = HOLD;
                        complete_c = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Ack takes priority; a simultaneous bit opens the next word.
                if (ack_in) begin
                    ack_c      = 1'b1;
                    next_state = IDLE;
                    if (accept_c) begin
                        next_state = COLLECT;
                        shift_c    = 1'b1;
                        start_c    = 1'b1;
                    end
                end else if (accept_c) begin
                    ovf_set_c = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            bit_count  <= '0;
            sr         <= '0;
            data_out   <= '0;
            data_ready <= 1'b0;
            status_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (complete_c) begin
                bit_count <= '0;
            end else if (start_c) begin
                bit_count <= CNT_W'(1);
            end else if (shift_c) begin
                bit_count <= bit_count + CNT_W'(1);
            end

            if (shift_c) begin
                sr <= SR_W'({sr, data_in});
            end

            if (complete_c) begin
                data_out <= word_c;
            end

            if (complete_c) begin
                data_ready <= 1'b1;
            end else if (ack_c) begin
                data_ready <= 1'b0;
            end

            if (ovf_set_c) begin
                overflow <= 1'b1;
            end

            status_out <= (next_state != IDLE);
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (complete_c) begin
            parity_err <= ^{sr, data_in};
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer (WIDTH=8), parity-aware when DESER_PARITY_EN is set.
module tb_deserializer;

    localparam int unsigned W = 8;
`ifdef DESER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic         clock_1M = 1'b0;
    logic         reset;
    logic         bit_strobe;
    logic         write_in;
    logic         data_in;
    logic         ack_in;
    logic [W-1:0] data_out;
    logic         data_ready;
    logic         status_out;
    logic         overflow;
    logic         parity_err;

    int   tests = 0;
    int   fails = 0;
    logic parity_flip = 1'b0;

    always #5 clock_1M = ~clock_1M;

    deserializer #(.WIDTH(W)) dut (
        .clock_1M   (clock_1M),
        .reset      (reset),
        .bit_strobe (bit_strobe),
        .write_in   (write_in),
        .data_in    (data_in),
        .ack_in     (ack_in),
        .data_out   (data_out),
        .data_ready (data_ready),
        .status_out (status_out),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit idx of a word in transmission order; index 8 is the even-parity bit.
    function automatic logic get_bit(input logic [7:0] v, input int idx, input logic flip);
        if (idx < 8) return v[7-idx];
        return (^v) ^ flip;
    endfunction

    // Called at a negedge; strobe high for 'hold' cycles then low for one.
    task automatic slot(input logic b, input logic wr, input int hold);
        bit_strobe = 1'b1;
        write_in   = wr;
        data_in    = b;
        repeat (hold) @(negedge clock_1M);
        bit_strobe = 1'b0;
        write_in   = 1'b0;
        data_in    = 1'b0;
        @(negedge clock_1M);
    endtask

    task automatic send_range(input logic [7:0] v, input int from, input int to, input int hold);
        for (int i = from; i <= to; i++) slot(get_bit(v, i, parity_flip), 1'b1, hold);
    endtask

    task automatic send_word(input logic [7:0] v, input int hold);
        send_range(v, 0, NB - 1, hold);
    endtask

    task automatic pulse_ack();
        ack_in = 1'b1;
        @(negedge clock_1M);
        ack_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, 16'(data_out), 16'h0);
        check({tag, "_ready"}, 16'(data_ready), 16'h0);
        check({tag, "_status"}, 16'(status_out), 16'h0);
        check({tag, "_overflow"}, 16'(overflow), 16'h0);
        check({tag, "_parity"}, 16'(parity_err), 16'h0);
    endtask

    initial begin
        reset      = 1'b0;
        bit_strobe = 1'b0;
        write_in   = 1'b0;
        data_in    = 1'b0;
        ack_in     = 1'b0;
        repeat (3) @(negedge clock_1M);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clock_1M);

        // 8'hB2 with one-cycle latency after the final slot
        send_range(8'hB2, 0, NB - 2, 1);
        check("b2_collect_status", 16'(status_out), 16'h1);
        check("b2_collect_not_ready", 16'(data_ready), 16'h0);
        bit_strobe = 1'b1;
        write_in   = 1'b1;
        data_in    = get_bit(8'hB2, NB - 1, 1'b0);
        @(negedge clock_1M);
        check("b2_ready", 16'(data_ready), 16'h1);
        check("b2_data", 16'(data_out), 16'h00B2);
        check("b2_parity", 16'(parity_err), 16'h0);
        bit_strobe = 1'b0;
        write_in   = 1'b0;
        data_in    = 1'b0;
        repeat (4) @(negedge clock_1M);
        check("b2_data_stable", 16'(data_out), 16'h00B2);
        check("b2_status_hold", 16'(status_out), 16'h1);
        pulse_ack();
        check("b2_ack_ready", 16'(data_ready), 16'h0);
        check("b2_ack_status", 16'(status_out), 16'h0);

        // Wide strobes, an ignored write_in=0 slot, and an ignored ack mid-word
        send_range(8'h3C, 0, 3, 5);
        slot(1'b1, 1'b0, 5);
        pulse_ack();
        check("3c_ack_ignored_status", 16'(status_out), 16'h1);
        check("3c_ack_ignored_ready", 16'(data_ready), 16'h0);
        send_range(8'h3C, 4, NB - 1, 5);
        check("3c_data", 16'(data_out), 16'h003C);
        check("3c_ready", 16'(data_ready), 16'h1);
        pulse_ack();

        // Overflow while 8'h5A is pending
        send_word(8'h5A, 1);
        check("5a_data", 16'(data_out), 16'h005A);
        check("5a_no_overflow", 16'(overflow), 16'h0);
        repeat (3) slot(1'b1, 1'b1, 1);
        check("5a_data_frozen", 16'(data_out), 16'h005A);
        check("5a_ready_held", 16'(data_ready), 16'h1);
        check("5a_overflow", 16'(overflow), 16'h1);
        pulse_ack();
        check("5a_ack_ready", 16'(data_ready), 16'h0);
        check("5a_ack_status", 16'(status_out), 16'h0);
        check("5a_overflow_sticky", 16'(overflow), 16'h1);

        // Ack and the first bit of the next word in the same cycle
        send_word(8'hC3, 1);
        check("c3_data", 16'(data_out), 16'h00C3);
        ack_in     = 1'b1;
        bit_strobe = 1'b1;
        write_in   = 1'b1;
        data_in    = get_bit(8'h96, 0, 1'b0);
        @(negedge clock_1M);
        ack_in     = 1'b0;
        bit_strobe = 1'b0;
        write_in   = 1'b0;
        data_in    = 1'b0;
        check("ackbit_ready", 16'(data_ready), 16'h0);
        check("ackbit_status", 16'(status_out), 16'h1);
        @(negedge clock_1M);
        send_range(8'h96, 1, NB - 1, 1);
        check("96_data", 16'(data_out), 16'h0096);
        check("96_ready", 16'(data_ready), 16'h1);
        pulse_ack();

        // Reset after a partial word
        send_range(8'h0F, 0, 3, 1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock_1M);
        reset = 1'b1;
        @(negedge clock_1M);
        send_word(8'hFF, 1);
        check("ff_data", 16'(data_out), 16'h00FF);
        check("ff_ready", 16'(data_ready), 16'h1);
        check("ff_overflow_cleared", 16'(overflow), 16'h0);
        pulse_ack();

`ifdef DESER_PARITY_EN
        parity_flip = 1'b0;
        send_word(8'hB2, 1);
        check("par_good_data", 16'(data_out), 16'h00B2);
        check("par_good", 16'(parity_err), 16'h0);
        pulse_ack();
        parity_flip = 1'b1;
        send_word(8'hB2, 1);
        check("par_bad_data", 16'(data_out), 16'h00B2);
        check("par_bad", 16'(parity_err), 16'h1);
        pulse_ack();
        parity_flip = 1'b0;
`else
        check("parity_tied_low", 16'(parity_err), 16'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits assembled per word (2..16).
REQ-002 clock_1M  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-004 bit_strobe  input  1  bit-rate strobe from the clock divider (100 kHz-derived); a 0->1 transition marks one bit slot.
REQ-005 write_in  input  1  serial bit valid; sampled together with data_in at a bit slot.
REQ-006 data_in  input  1  serial data bit, MSB first.
REQ-007 ack_in  input  1  consumer accepts data_out; single-cycle or level, sampled on clock_1M.
REQ-008 data_out  output  WIDTH  assembled word; stable while data_ready=1.
REQ-009 data_ready  output  1  word available; held until acknowledged.
REQ-010 status_out  output  1  1 while collecting (bit_count>0) or holding a word; 0 when idle.
REQ-011 overflow  output  1  sticky: a valid bit arrived while a word was pending.
REQ-012 parity_err  output  1  parity check result for the current word (see Configuration).

Function
REQ-013 Bit slot = clock_1M cycle where registered bit_strobe_q=0 and bit_strobe=1; one slot per rising edge, regardless of strobe width.
REQ-014 Bits are accepted only in a slot with write_in=1; a slot with write_in=0 is ignored and bit_count is unchanged.
REQ-015 FSM states: IDLE, COLLECT, HOLD.
REQ-016 IDLE -> COLLECT on the first accepted bit; shift register gets {sr[WIDTH-2:0], data_in}; bit_count=1.
REQ-017 COLLECT: each accepted bit shifts in and increments bit_count; when the WIDTH-th bit is accepted, data_out is loaded with the completed word the next cycle, data_ready=1, state -> HOLD, bit_count=0 (latency one clock_1M cycle after the slot).
REQ-018 HOLD: data_out and data_ready are frozen; ack_in=1 -> data_ready=0 and state -> IDLE the next cycle.
REQ-019 Accepted bit in HOLD without ack_in in the same cycle -> bit discarded, overflow=1 (sticky until reset).
REQ-020 ack_in and an accepted bit in the same HOLD cycle -> ack wins, the bit is taken as the first bit of the next word, state -> COLLECT.
REQ-021 ack_in in IDLE or COLLECT is ignored.
REQ-022 bit_count width = $clog2(WIDTH)+1; no wrap beyond WIDTH.

Reset
REQ-023 Reset asserted: state=IDLE, bit_count=0, shift register=0, bit_strobe_q=0, data_out=0, data_ready=0, status_out=0, overflow=0, parity_err=0.
REQ-024 Reset mid-word or in HOLD discards the partial/pending word; the first slot after release starts a fresh word.

Configuration
REQ-025 Macro DESER_PARITY_EN defined: each word is WIDTH data bits followed by one even-parity bit (WIDTH+1 accepted bits); the parity bit is not placed in data_out; parity_err = XOR of data bits and parity bit, updated with data_ready and valid while data_ready=1.
REQ-026 DESER_PARITY_EN undefined: a word is WIDTH bits; parity_err is tied to 0.

Structure
REQ-027 Package deser_pkg holds the state enum (IDLE, COLLECT, HOLD) and the default WIDTH constant.
REQ-028 Sub-module edge_detect (registered 0->1 pulse generator, asynchronous active-low reset) implements REQ-013.

Verification
REQ-029 WIDTH=8, send 1,0,1,1,0,0,1,0 in 8 slots with write_in=1 -> data_out=8'hB2, data_ready=1 one cycle after the 8th slot, status_out=1 until ack.
REQ-030 bit_strobe held high 5 cycles per slot -> exactly one bit per slot; 8 slots -> one word.
REQ-031 Word 8'h5A pending, 3 more valid slots without ack -> data_out stays 8'h5A, overflow=1; ack -> data_ready=0, state IDLE.
REQ-032 ack_in and first bit of the next word in the same cycle -> data_ready=0, status_out=1, the following 7 bits complete the second word correctly.
REQ-033 Reset pulsed after 4 bits -> all outputs 0; next 8 bits 8'hFF -> data_out=8'hFF.
REQ-034 DESER_PARITY_EN: 8'hB2 plus parity bit 0 -> parity_err=0; same data with parity bit 1 -> parity_err=1.
